cv32e40p_hwloop_ctrl: RTL and testbench



---
 rtl/cv32e40p_hwlp_pkg.sv | 11 +
 rtl/cv32e40p_hwlp_match.sv | 28 ++
 rtl/cv32e40p_hwloop_ctrl.sv | 144 ++++++++++++++
 tb/tb_cv32e40p_hwloop_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_hwlp_pkg.sv
// Shared types and constants for the hardware-loop controller.
package cv32e40p_hwlp_pkg;

  typedef enum logic {
    HWLP_IDLE = 1'b0,
    HWLP_PEND = 1'b1
  } hwlp_state_e;

  localparam int HWLP_N_REGS_DEFAULT = 2;

endpackage

// File: rtl/cv32e40p_hwlp_match.sv
// Per-loop active/end-address compare with a priority encoder; index 0 wins.
module cv32e40p_hwlp_match #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic [31:0]          pc,
  input  logic [N_REGS*32-1:0] end_addr,
  input  logic [N_REGS*32-1:0] counter,
  output logic                 match_valid,
  output logic [N_REG_BITS-1:0] match_idx,
  output logic                 counter_is_one
);

  // Scan from the highest index down so the lowest matching index is the last writer.
  always_comb begin
    match_valid    = 1'b0;
    match_idx      = '0;
    counter_is_one = 1'b0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if ((counter[k*32 +: 32] != 32'd0) && (pc == end_addr[k*32 +: 32])) begin
        match_valid    = 1'b1;
        match_idx      = N_REG_BITS'(k);
        counter_is_one = (counter[k*32 +: 32] == 32'd1);
      end
    end
  end

endmodule

// File: rtl/cv32e40p_hwloop_ctrl.sv
// Hardware-loop controller: loop-back decision, counter decrement and jump handshake to fetch.
// Optional event counters are built when CV32E40P_HWLP_STATS_EN is defined.
module cv32e40p_hwloop_ctrl
  import cv32e40p_hwlp_pkg::*;
#(
  parameter int N_REGS     = HWLP_N_REGS_DEFAULT,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           id_pc_i,
  input  logic                  id_valid_i,
  input  logic                  flush_i,
  input  logic [N_REGS*32-1:0]  hwlp_start_addr_i,
  input  logic [N_REGS*32-1:0]  hwlp_end_addr_i,
  input  logic [N_REGS*32-1:0]  hwlp_counter_i,
  output logic [N_REGS-1:0]     hwlp_dec_cnt_o,
  output logic                  hwlp_jump_o,
  output logic [31:0]           hwlp_target_o,
  output logic [N_REG_BITS-1:0] hwlp_loop_id_o,
  input  logic                  jump_ack_i
`ifdef CV32E40P_HWLP_STATS_EN
  ,
  output logic [31:0]           hwlp_taken_cnt_o,
  output logic [31:0]           hwlp_exit_cnt_o
`endif
);

  // Handshake: hwlp_jump_o is held with a stable hwlp_target_o/hwlp_loop_id_o until the
  // cycle fetch raises jump_ack_i (inclusive); jump_ack_i while hwlp_jump_o=0 is ignored.

  hwlp_state_e           state_q, state_d;
  logic [31:0]           target_q, target_d;
  logic [N_REG_BITS-1:0] loop_id_q, loop_id_d;

  logic                  match_valid;
  logic [N_REG_BITS-1:0] match_idx;
  logic                  counter_is_one;
  logic                  event_valid;
  logic                  taken;
  logic                  loop_exit;
  logic [31:0]           sel_start;

  cv32e40p_hwlp_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .pc             (id_pc_i),
    .end_addr       (hwlp_end_addr_i),
    .counter        (hwlp_counter_i),
    .match_valid    (match_valid),
    .match_idx      (match_idx),
    .counter_is_one (counter_is_one)
  );

  // A flush in the same cycle suppresses the event entirely, decrement included.
  assign event_valid = id_valid_i & ~flush_i & match_valid;
  assign taken       = event_valid & ~counter_is_one;
  assign loop_exit   = event_valid & counter_is_one;

  always_comb begin
    hwlp_dec_cnt_o = '0;
    sel_start      = 32'd0;
    for (int k = 0; k < N_REGS; k++) begin
      if (match_idx == N_REG_BITS'(k)) begin
        hwlp_dec_cnt_o[k] = event_valid;
        sel_start         = hwlp_start_addr_i[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    loop_id_d = loop_id_q;
    case (state_q)
      HWLP_IDLE: begin
        if (taken) begin
          state_d   = HWLP_PEND;
          target_d  = sel_start;
          loop_id_d = match_idx;
        end
      end
      HWLP_PEND: begin
        if (flush_i) begin
          state_d = HWLP_IDLE;
        end else if (taken) begin
          state_d   = HWLP_PEND;
          target_d  = sel_start;
          loop_id_d = match_idx;
        end else if (jump_ack_i) begin
          state_d = HWLP_IDLE;
        end
      end
      default: state_d = HWLP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HWLP_IDLE;
      target_q  <= 32'd0;
      loop_id_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      loop_id_q <= loop_id_d;
    end
  end

  assign hwlp_jump_o    = (state_q == HWLP_PEND);
  assign hwlp_target_o  = target_q;
  assign hwlp_loop_id_o = loop_id_q;

`ifdef CV32E40P_HWLP_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] exit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 32'd0;
      exit_cnt_q  <= 32'd0;
    end else begin
      if (taken)     taken_cnt_q <= taken_cnt_q + 32'd1;
      if (loop_exit) exit_cnt_q  <= exit_cnt_q + 32'd1;
    end
  end

  assign hwlp_taken_cnt_o = taken_cnt_q;
  assign hwlp_exit_cnt_o  = exit_cnt_q;
`else
  logic unused_exit;
  assign unused_exit = loop_exit;
`endif

`ifdef CV32E40P_ASSERT_ON
  // A new taken event while a jump is still unacknowledged would silently drop that jump.
  a_no_overwrite_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    !((state_q == HWLP_PEND) && taken && !jump_ack_i)
  ) else $error("hwloop: taken event while jump pending without ack");
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// Self-checking bench for cv32e40p_hwloop_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the loop-back rules.
module tb_cv32e40p_hwloop_ctrl;

  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      id_pc    = 32'd0;
  logic             id_valid = 1'b0;
  logic             flush    = 1'b0;
  logic             ack      = 1'b0;
  logic [31:0]      st  [N];
  logic [31:0]      en  [N];
  logic [31:0]      cnt [N];
  logic [N*32-1:0]  st_flat, en_flat, cnt_flat;

  logic [N-1:0]     dec;
  logic             jump;
  logic [31:0]      target;
  logic [0:0]       loop_id;
`ifdef CV32E40P_HWLP_STATS_EN
  logic [31:0]      taken_cnt, exit_cnt;
`endif

  always_comb begin
    st_flat  = '0;
    en_flat  = '0;
    cnt_flat = '0;
    for (int k = 0; k < N; k++) begin
      st_flat[k*32 +: 32]  = st[k];
      en_flat[k*32 +: 32]  = en[k];
      cnt_flat[k*32 +: 32] = cnt[k];
    end
  end

  cv32e40p_hwloop_ctrl #(.N_REGS(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_pc_i           (id_pc),
    .id_valid_i        (id_valid),
    .flush_i           (flush),
    .hwlp_start_addr_i (st_flat),
    .hwlp_end_addr_i   (en_flat),
    .hwlp_counter_i    (cnt_flat),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
    .hwlp_loop_id_o    (loop_id),
    .jump_ack_i        (ack)
`ifdef CV32E40P_HWLP_STATS_EN
    ,
    .hwlp_taken_cnt_o  (taken_cnt),
    .hwlp_exit_cnt_o   (exit_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: whether a jump is owed to fetch, and where to.
  bit           m_pend   = 1'b0;
  logic [31:0]  m_target = 32'd0;
  int           m_id     = 0;
  logic [N-1:0] exp_dec_last = '0;
  logic [31:0]  m_taken_n = 32'd0;
  logic [31:0]  m_exit_n  = 32'd0;

  always @(negedge clk) begin
    int           sel;
    bit           ev;
    logic [N-1:0] e_dec;
    if (!rst_n) begin
      chk("rst_jump", 32'(jump), 32'd0);
      chk("rst_target", target, 32'd0);
      chk("rst_id", 32'(loop_id), 32'd0);
      chk("rst_dec", 32'(dec), 32'd0);
      m_pend = 1'b0; m_target = 32'd0; m_id = 0;
      exp_dec_last = '0; m_taken_n = 32'd0; m_exit_n = 32'd0;
    end else begin
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && cnt[k] != 32'd0 && id_pc == en[k]) sel = k;
      ev    = id_valid && !flush && sel >= 0;
      e_dec = '0;
      if (ev) e_dec[sel] = 1'b1;
      chk("cyc_dec", 32'(dec), 32'(e_dec));
      chk("cyc_jump", 32'(jump), 32'(m_pend));
      if (m_pend) begin
        chk("cyc_target", target, m_target);
        chk("cyc_id", 32'(loop_id), 32'(m_id));
      end
`ifdef CV32E40P_HWLP_STATS_EN
      chk("cyc_taken_cnt", taken_cnt, m_taken_n);
      chk("cyc_exit_cnt", exit_cnt, m_exit_n);
`endif
      exp_dec_last = e_dec;
      if (ev && cnt[sel] >= 32'd2) m_taken_n++;
      if (ev && cnt[sel] == 32'd1) m_exit_n++;
      if (flush) m_pend = 1'b0;
      else if (ev && cnt[sel] >= 32'd2) begin
        m_pend = 1'b1; m_target = st[sel]; m_id = sel;
      end else if (ack && m_pend) m_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // The bench plays the register file: counters drop by the decrement the model expects.
  task automatic step(input logic [31:0] pc, input logic v, input logic f, input logic a);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++)
      if (exp_dec_last[k]) cnt[k] = cnt[k] - 32'd1;
    id_pc = pc; id_valid = v; flush = f; ack = a;
  endtask

  task automatic set_loop(input int k, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    st[k] = s; en[k] = e; cnt[k] = c;
  endtask

  task automatic idle();
    step(32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < N; k++) set_loop(k, 32'd0, 32'hFFFF_FFF0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Single loop, count 3: two jumps then an exit.
    set_loop(0, 32'h100, 32'h10C, 32'd3);
    set_loop(1, 32'h800, 32'h900, 32'd0);
    idle();
    step(32'h10C, 1, 0, 0); #2 chk("t1_dec_a", 32'(dec), 32'h1);
    step(32'h104, 0, 0, 1); #2 chk("t1_jump_a", 32'(jump), 32'd1);
    chk("t1_target_a", target, 32'h100);
    step(32'h10C, 1, 0, 0); #2 chk("t1_dec_b", 32'(dec), 32'h1);
    step(32'h000, 0, 0, 1); #2 chk("t1_jump_b", 32'(jump), 32'd1);
    step(32'h10C, 1, 0, 0); #2 chk("t1_dec_exit", 32'(dec), 32'h1);
    idle(); #2 chk("t1_no_jump", 32'(jump), 32'd0);

    // Nested loops.
    set_loop(0, 32'h200, 32'h20C, 32'd2);
    set_loop(1, 32'h1F0, 32'h220, 32'd2);
    idle();
    step(32'h20C, 1, 0, 0); #2 chk("t2_dec0", 32'(dec), 32'h1);
    step(32'h000, 0, 0, 1); #2 chk("t2_target0", target, 32'h200);
    step(32'h220, 1, 0, 0); #2 chk("t2_dec1", 32'(dec), 32'h2);
    step(32'h000, 0, 0, 1); #2 chk("t2_target1", target, 32'h1F0);
    chk("t2_id1", 32'(loop_id), 32'd1);

    // Same end address on both loops: loop 0 wins.
    set_loop(0, 32'h2F0, 32'h300, 32'd5);
    set_loop(1, 32'h280, 32'h300, 32'd5);
    idle();
    step(32'h300, 1, 0, 0); #2 chk("t3_dec", 32'(dec), 32'h1);
    step(32'h000, 0, 0, 1); #2 chk("t3_target", target, 32'h2F0);

    // Fetch stalls the ack for four cycles.
    step(32'h300, 1, 0, 0);
    repeat (4) begin
      idle(); #2 chk("t4_hold_jump", 32'(jump), 32'd1);
      chk("t4_hold_target", target, 32'h2F0);
      chk("t4_hold_dec", 32'(dec), 32'd0);
    end
    step(32'h000, 0, 0, 1); #2 chk("t4_ack_jump", 32'(jump), 32'd1);
    idle(); #2 chk("t4_drop", 32'(jump), 32'd0);

    // Flush after a taken event, then flush coincident with an event.
    step(32'h300, 1, 0, 0);
    step(32'h000, 0, 1, 0); #2 chk("t5_jump_on_flush", 32'(jump), 32'd1);
    idle(); #2 chk("t5_flushed", 32'(jump), 32'd0);
    step(32'h300, 1, 1, 0); #2 chk("t5_flush_dec", 32'(dec), 32'd0);
    idle(); #2 chk("t5_flush_nojump", 32'(jump), 32'd0);

    // Matching end address with an inactive loop.
    set_loop(0, 32'h500, 32'h50C, 32'd0);
    set_loop(1, 32'h540, 32'h50C, 32'd0);
    idle();
    step(32'h50C, 1, 0, 0); #2 chk("t6_dec", 32'(dec), 32'd0);
    idle(); #2 chk("t6_jump", 32'(jump), 32'd0);

    // Asynchronous reset while a jump is pending.
    set_loop(0, 32'h600, 32'h60C, 32'd4);
    idle();
    step(32'h60C, 1, 0, 0);
    idle(); #2 chk("t7_pend", 32'(jump), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("t7_rst_jump", 32'(jump), 32'd0);
    chk("t7_rst_target", target, 32'd0);
    chk("t7_rst_id", 32'(loop_id), 32'd0);
    chk("t7_rst_dec", 32'(dec), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        for (int k = 0; k < N; k++)
          set_loop(k, {$urandom_range(0, 255), 2'b00} + 32'h1000,
                   32'h400 + 32'($urandom_range(0, 3)) * 4, 32'($urandom_range(0, 3)));
      end
      step(($urandom_range(0, 9) < 8) ? 32'h400 + 32'($urandom_range(0, 3)) * 4 : 32'($urandom),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)));
      if (i % 16 == 15) begin
        for (int k = 0; k < N; k++)
          if (cnt[k] == 32'd0) cnt[k] = 32'($urandom_range(1, 4));
      end
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
